alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal range 8..64.
REQ-002 SHALL have parameter M_EXT, default 1, meaning 1 = RV32M multiply/divide sequencing enabled, 0 = M requests decoded as illegal.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 valid_i  in  1  request present.
REQ-006 ready_o  out  1  block can accept a request this cycle.
REQ-007 kill_i  in  1  abort any in-flight M operation.
REQ-008 funct7_i  in  7  instruction funct7 field.
REQ-009 ALU_Op_i  in  3  operation class from main control.
REQ-010 funct3_i  in  3  instruction funct3 field.
REQ-011 rs1_i, rs2_i  in  WIDTH each  M-operation operands (dividend/multiplicand, divisor/multiplier).
REQ-012 alu_operation_o  out  4  registered ALU operation code.
REQ-013 op_valid_o  out  1  one-cycle pulse: alu_operation_o updated.
REQ-014 illegal_o  out  1  one-cycle pulse: accepted request undecodable.
REQ-015 m_result_o  out  WIDTH  M-operation result, held until next M completion.
REQ-016 m_done_o  out  1  one-cycle pulse: m_result_o valid.

Function
REQ-017 Accept SHALL occur on a rising edge with valid_i=1 and ready_o=1; ready_o=1 only in state IDLE.
REQ-018 Base decode (key {funct7_i[5], ALU_Op_i, funct3_i}) SHALL be: R 000: ADD/SUB(f7[5]=1) 0000/0001, AND 0010, OR 0011, XOR 0100, SRL 0101, SLL 0110; I 001: ADDI 0000, ANDI 0010, ORI 0011, XORI 0100, SRLI 0101, SLLI 0110 (shifts only with f7[5]=0); U 010: LUI 0111; B 100: BEQ 1000, BNE 1001, BLT 1010, BGE 1011; S 011 f3=010: 0000; JALR 101 f3=000: 0000; LW 110 f3=010: 0000; JAL 111: 0000; anything else: 1111.
REQ-019 R-type with funct7_i other than 0000000/0100000/0000001 SHALL decode as 1111.
REQ-020 Non-M accept: alu_operation_o and op_valid_o=1 SHALL appear on the next edge (latency 1); illegal_o=1 in the same cycle when code is 1111; block stays IDLE (back-to-back accepts allowed every cycle).
REQ-021 M request = ALU_Op_i=000, funct7_i=0000001, M_EXT=1; funct3: 000 MUL (low WIDTH bits), 011 MULHU (high WIDTH bits, unsigned), 100 DIV, 101 DIVU, 110 REM, 111 REMU; 001/010 SHALL decode as illegal (1111, illegal_o) without entering the FSM.
REQ-022 M accept SHALL capture operands and funct3, set alu_operation_o=1100 with op_valid_o pulse, and move IDLE->CALC.
REQ-023 FSM states IDLE, CALC, FIX, DONE: CALC performs one shift-add (mul) or restoring-subtract (div) step per cycle for exactly WIDTH cycles, then FIX; FIX applies sign correction, then DONE; DONE pulses m_done_o, then IDLE.
REQ-024 m_done_o SHALL rise exactly WIDTH+2 edges after the accepting edge (34 for WIDTH=32).
REQ-025 Signed DIV/REM SHALL divide magnitudes; quotient negated when signs differ, remainder takes dividend sign.
REQ-026 Divide by zero SHALL skip CALC (IDLE->FIX->DONE, m_done_o 2 edges after accept): quotient all-ones, remainder = rs1.
REQ-027 Signed overflow (most-negative / -1) SHALL yield quotient = dividend, remainder = 0.
REQ-028 kill_i=1 in CALC, FIX or DONE SHALL return to IDLE on that edge with no m_done_o and m_result_o unchanged; kill_i in IDLE SHALL have no effect; kill_i has priority over completion.
REQ-029 valid_i while ready_o=0 SHALL be ignored (requester holds request); no request is queued.

Reset
REQ-030 reset=1 SHALL, on the edge, force IDLE, alu_operation_o=0000, m_result_o=0, op_valid_o=0, illegal_o=0, m_done_o=0, ready_o=1 next cycle; reset has priority over valid_i and kill_i; an in-flight M operation is discarded.

Structure
REQ-031 Operation codes, decode-key constants and FSM state encoding SHALL reside in shared package alu_pkg.
REQ-032 Iterative datapath (accumulator, shift register, step counter, sign fix) SHALL be sub-module mdu_iterative; decode and FSM in alu_op_sequencer.

Verification
REQ-033 ALU_Op=000,f7=0100000,f3=000 -> next cycle alu_operation_o=0001, op_valid_o=1; 10 back-to-back mixed base ops -> one code per cycle, ready_o constant 1.
REQ-034 MUL rs1=0xFFFF_FFFF, rs2=0x2 -> m_result_o=0xFFFF_FFFE, m_done_o at edge 34; MULHU same operands -> 0x0000_0001.
REQ-035 DIV rs1=0x8000_0000, rs2=0xFFFF_FFFF -> 0x8000_0000; REM same -> 0; DIV -7/2 -> 0xFFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF.
REQ-036 DIVU rs1=5, rs2=0 -> 0xFFFF_FFFF at edge 2; REMU -> 5.
REQ-037 kill_i at edge 10 of a DIVU -> IDLE, ready_o=1 next cycle, no m_done_o; reset at edge 20 of a MUL -> all outputs zero, no m_done_o.
REQ-038 f7=0000001, f3=001 and ALU_Op=011,f3=000 -> alu_operation_o=1111, illegal_o=1, FSM stays IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: operation codes,
// decode-key constants, FSM state encoding and the base-ISA decode function.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // ALU operation codes driven on alu_operation_o
  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_AND     = 4'b0010;
  localparam logic [3:0] OP_OR      = 4'b0011;
  localparam logic [3:0] OP_XOR     = 4'b0100;
  localparam logic [3:0] OP_SRL     = 4'b0101;
  localparam logic [3:0] OP_SLL     = 4'b0110;
  localparam logic [3:0] OP_LUI     = 4'b0111;
  localparam logic [3:0] OP_BEQ     = 4'b1000;
  localparam logic [3:0] OP_BNE     = 4'b1001;
  localparam logic [3:0] OP_BLT     = 4'b1010;
  localparam logic [3:0] OP_BGE     = 4'b1011;
  localparam logic [3:0] OP_MDU     = 4'b1100;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  // Operation classes from main control
  localparam logic [2:0] ALUOP_R    = 3'b000;
  localparam logic [2:0] ALUOP_I    = 3'b001;
  localparam logic [2:0] ALUOP_U    = 3'b010;
  localparam logic [2:0] ALUOP_S    = 3'b011;
  localparam logic [2:0] ALUOP_B    = 3'b100;
  localparam logic [2:0] ALUOP_JALR = 3'b101;
  localparam logic [2:0] ALUOP_LW   = 3'b110;
  localparam logic [2:0] ALUOP_JAL  = 3'b111;

  // funct7 values accepted for R-type
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 values for the base integer operations
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // funct3 values for the multiply/divide group
  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULH  = 3'b001;
  localparam logic [2:0] F3_MULSU = 3'b010;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIV   = 3'b100;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REM   = 3'b110;
  localparam logic [2:0] F3_REMU  = 3'b111;

  // Base (non-M) decode; any R-type funct7 other than BASE/ALT is illegal here,
  // the multiply/divide group is overridden by the sequencer itself.
  function automatic logic [3:0] base_decode(input logic [6:0] f7,
                                             input logic [2:0] alu_op,
                                             input logic [2:0] f3);
    logic [3:0] code;
    code = OP_ILLEGAL;
    case (alu_op)
      ALUOP_R: begin
        if (f7 == F7_BASE) begin
          case (f3)
            F3_ADD:  code = OP_ADD;
            F3_AND:  code = OP_AND;
            F3_OR:   code = OP_OR;
            F3_XOR:  code = OP_XOR;
            F3_SRL:  code = OP_SRL;
            F3_SLL:  code = OP_SLL;
            default: code = OP_ILLEGAL;
          endcase
        end else if (f7 == F7_ALT && f3 == F3_ADD) begin
          code = OP_SUB;
        end
      end
      ALUOP_I: begin
        // funct7 is immediate bits for I-type, only shifts constrain bit 5
        case (f3)
          F3_ADD:  code = OP_ADD;
          F3_AND:  code = OP_AND;
          F3_OR:   code = OP_OR;
          F3_XOR:  code = OP_XOR;
          F3_SRL:  code = f7[5] ? OP_ILLEGAL : OP_SRL;
          F3_SLL:  code = f7[5] ? OP_ILLEGAL : OP_SLL;
          default: code = OP_ILLEGAL;
        endcase
      end
      ALUOP_U: code = OP_LUI;
      ALUOP_B: begin
        case (f3)
          F3_BEQ:  code = OP_BEQ;
          F3_BNE:  code = OP_BNE;
          F3_BLT:  code = OP_BLT;
          F3_BGE:  code = OP_BGE;
          default: code = OP_ILLEGAL;
        endcase
      end
      ALUOP_S:    code = (f3 == F3_W)   ? OP_ADD : OP_ILLEGAL;
      ALUOP_JALR: code = (f3 == F3_ADD) ? OP_ADD : OP_ILLEGAL;
      ALUOP_LW:   code = (f3 == F3_W)   ? OP_ADD : OP_ILLEGAL;
      ALUOP_JAL:  code = OP_ADD;
      default:    code = OP_ILLEGAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide datapath: one shift-add or restoring-subtract step
// per step_i cycle, magnitude-based signed divide with a final sign-fix cycle.
module mdu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             start_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic             last_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  // Two's-complement magnitude; the most-negative value maps to itself,
  // which is its correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] s;
    s = $signed(v);
    return $unsigned(-s);
  endfunction

  // acc_q: product high half / partial remainder
  // q_q:   multiplier shifting out, product low half / quotient shifting in
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] res_q;
  logic [2:0]       f3_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             div0_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] fix_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;

  logic             ld_div;
  logic             ld_signed;
  logic             ld_div0;
  logic [WIDTH-1:0] ld_q;
  logic [WIDTH-1:0] ld_opb;

  // Operand preparation at start: magnitudes for signed divide, raw dividend
  // kept on divide-by-zero so the remainder can return it unchanged.
  always_comb begin
    ld_div    = funct3_i[2];
    ld_signed = ld_div && !funct3_i[0];
    ld_div0   = ld_div && (rs2_i == '0);
    ld_q      = rs2_i;
    ld_opb    = rs1_i;
    if (ld_div) begin
      ld_q   = (ld_signed && !ld_div0) ? magnitude(rs1_i) : rs1_i;
      ld_opb = ld_signed ? magnitude(rs2_i) : rs2_i;
    end
  end

  // One iteration step for multiply (shift-add) or divide (restoring)
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_q, q_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    acc_d     = acc_q;
    q_d       = q_q;
    if (f3_q[2]) begin
      if (!div_diff[WIDTH+1]) begin
        acc_d = div_diff[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = div_shift[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_d = mul_sum[WIDTH:1];
      q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
    end
  end

  // Result selection and sign correction; signed overflow (min / -1) falls out
  // naturally as quotient = dividend, remainder = 0.
  always_comb begin
    fix_d = q_q;
    case (f3_q)
      F3_MUL:   fix_d = q_q;
      F3_MULHU: fix_d = acc_q;
      F3_DIV:   fix_d = div0_q ? '1 : (neg_quo_q ? negate(q_q) : q_q);
      F3_DIVU:  fix_d = div0_q ? '1 : q_q;
      F3_REM:   fix_d = div0_q ? q_q : (neg_rem_q ? negate(acc_q) : acc_q);
      F3_REMU:  fix_d = div0_q ? q_q : acc_q;
      default:  fix_d = q_q;
    endcase
  end

  // Datapath registers: load on start, iterate on step, latch result on fix
  always_ff @(posedge clk) begin
    if (start_i) begin
      f3_q      <= funct3_i;
      acc_q     <= '0;
      q_q       <= ld_q;
      opb_q     <= ld_opb;
      cnt_q     <= CW'(WIDTH - 1);
      div0_q    <= ld_div0;
      neg_quo_q <= ld_signed && (rs1_i[WIDTH-1] ^ rs2_i[WIDTH-1]);
      neg_rem_q <= ld_signed && rs1_i[WIDTH-1];
    end else if (step_i) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      cnt_q <= cnt_q - 1'b1;
    end else if (fix_i) begin
      res_q <= fix_d;
    end
  end

  assign last_o   = (cnt_q == '0);
  assign result_o = res_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: single-cycle base-ISA decode plus an IDLE/CALC/FIX/
// DONE controller around the iterative multiply/divide datapath.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int M_EXT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             kill_i,
  input  logic [6:0]       funct7_i,
  input  logic [2:0]       ALU_Op_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic [3:0]       alu_operation_o,
  output logic             op_valid_o,
  output logic             illegal_o,
  output logic [WIDTH-1:0] m_result_o,
  output logic             m_done_o
);

  state_e           state_q;
  logic [3:0]       alu_op_q;
  logic             op_valid_q;
  logic             illegal_q;
  logic             m_done_q;
  logic [WIDTH-1:0] m_result_q;

  logic             is_m_req;
  logic             m_f3_ok;
  logic             m_start;
  logic             div_zero;
  logic [3:0]       dec_code;
  logic             mdu_last;
  logic [WIDTH-1:0] mdu_result;

  // Request classification and decode for the accepting cycle
  always_comb begin
    is_m_req = (M_EXT != 0) && (ALU_Op_i == ALUOP_R) && (funct7_i == F7_MULDIV);
    m_f3_ok  = (funct3_i != F3_MULH) && (funct3_i != F3_MULSU);
    div_zero = funct3_i[2] && (rs2_i == '0);
    m_start  = (state_q == ST_IDLE) && valid_i && is_m_req && m_f3_ok;
    if (is_m_req) begin
      dec_code = m_f3_ok ? OP_MDU : OP_ILLEGAL;
    end else begin
      dec_code = base_decode(funct7_i, ALU_Op_i, funct3_i);
    end
  end

  mdu_iterative #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk     (clk),
    .start_i (m_start),
    .step_i  (state_q == ST_CALC),
    .fix_i   (state_q == ST_FIX),
    .funct3_i(funct3_i),
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .last_o  (mdu_last),
    .result_o(mdu_result)
  );

  // Sequencer FSM with registered outputs; kill wins over completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      alu_op_q   <= OP_ADD;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      m_done_q   <= 1'b0;
      m_result_q <= '0;
    end else begin
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      m_done_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (valid_i) begin
            alu_op_q   <= dec_code;
            op_valid_q <= 1'b1;
            illegal_q  <= (dec_code == OP_ILLEGAL);
            if (m_start) begin
              state_q <= div_zero ? ST_FIX : ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (kill_i) begin
            state_q <= ST_IDLE;
          end else if (mdu_last) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          state_q <= kill_i ? ST_IDLE : ST_DONE;
        end
        ST_DONE: begin
          if (!kill_i) begin
            m_done_q   <= 1'b1;
            m_result_q <= mdu_result;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ready_o         = (state_q == ST_IDLE);
  assign alu_operation_o = alu_op_q;
  assign op_valid_o      = op_valid_q;
  assign illegal_o       = illegal_q;
  assign m_done_o        = m_done_q;
  assign m_result_o      = m_result_q;

endmodule
